// File: rtl/dec_n_to_2n_seq.sv
// Sequential N-to-2**N decoder with level, timed-pulse and rotating-scan
// request modes. A request handshake (a_valid/a_ready) selects the mode.
// D, busy and err are all driven from registers.
module dec_n_to_2n_seq #(
   parameter int N         = 3,
   parameter int PULSE_CYC = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [N-1:0]     A,
   input  logic [1:0]       mode,
   input  logic             a_valid,
   output logic             a_ready,
   output logic [2**N-1:0]  D,
   output logic             busy,
   output logic             err
);

   localparam int W = 2**N;

   // The counter holds the number of one-hot cycles still to follow the
   // current one, so it loads with (length - 1).
   localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYC - 1);
   localparam logic [7:0] SCAN_LOAD  = 8'(W - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LEVEL = 2'd1,
      ST_PULSE = 2'd2,
      ST_SCAN  = 2'd3
   } state_t;

   state_t       state;
   state_t       state_nxt;
   logic [7:0]   cnt;
   logic [7:0]   cnt_nxt;
   logic [W-1:0] d_nxt;
   logic         err_nxt;
   logic         busy_nxt;
   logic         accept;

   function automatic logic [W-1:0] onehot(input logic [N-1:0] sel);
      logic [W-1:0] v;
      v      = '0;
      v[sel] = 1'b1;
      return v;
   endfunction

   function automatic logic [W-1:0] rotl(input logic [W-1:0] v);
      return {v[W-2:0], v[W-1]};
   endfunction

   // Requests are only taken while not running a timed operation.
   assign a_ready = en && ((state == ST_IDLE) || (state == ST_LEVEL));
   assign accept  = a_valid && a_ready;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state selection: disable wins, then a new request, then timeout.
   always_comb begin
      state_nxt = state;
      if (!en) begin
         state_nxt = ST_IDLE;
      end else if (accept) begin
         case (mode)
            2'b00:   state_nxt = ST_LEVEL;
            2'b01:   state_nxt = ST_PULSE;
            2'b10:   state_nxt = ST_SCAN;
            default: state_nxt = ST_IDLE;
         endcase
      end else if ((state == ST_PULSE) || (state == ST_SCAN)) begin
         if (cnt == 8'd0) state_nxt = ST_IDLE;
      end
   end

   // Next values of the registered outputs and the cycle counter.
   always_comb begin
      d_nxt    = D;
      cnt_nxt  = cnt;
      err_nxt  = 1'b0;
      if (!en) begin
         d_nxt   = '0;
         cnt_nxt = 8'd0;
      end else if (accept) begin
         case (mode)
            2'b00: begin
               d_nxt   = onehot(A);
               cnt_nxt = 8'd0;
            end
            2'b01: begin
               d_nxt   = onehot(A);
               cnt_nxt = PULSE_LOAD;
            end
            2'b10: begin
               d_nxt   = onehot(A);
               cnt_nxt = SCAN_LOAD;
            end
            default: begin
               d_nxt   = '0;
               cnt_nxt = 8'd0;
               err_nxt = 1'b1;
            end
         endcase
      end else if (state == ST_PULSE) begin
         if (cnt == 8'd0) d_nxt = '0;
         else             cnt_nxt = cnt - 8'd1;
      end else if (state == ST_SCAN) begin
         if (cnt == 8'd0) begin
            d_nxt = '0;
         end else begin
            d_nxt   = rotl(D);
            cnt_nxt = cnt - 8'd1;
         end
      end
      busy_nxt = (state_nxt == ST_PULSE) || (state_nxt == ST_SCAN);
   end

   // Output and counter registers; reset clears everything at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         D    <= '0;
         cnt  <= 8'd0;
         err  <= 1'b0;
         busy <= 1'b0;
      end else begin
         D    <= d_nxt;
         cnt  <= cnt_nxt;
         err  <= err_nxt;
         busy <= busy_nxt;
      end
   end

endmodule
